// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the pipelined core.
// Owns the PC, addresses the combinational program ROM and registers each
// fetched word toward decode. Handles branch redirects, JUMP words,
// downstream stalls and program HALT.
//
// Optional macro HAZARD_INTERLOCK_EN: adds a per-register busy scoreboard
// that inserts bubbles on RAW hazards instead of relying on program NOPs.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start               one-cycle pulse, IDLE -> RUN fetching from address 0
//   stall_in            downstream hold: PC and fetch outputs freeze
//   br_taken, br_target taken branch from execute; flushes one word
//   rom_data            ROM word at pc_addr (combinational)
//   pc_addr             ROM address (current PC)
//   instr_out, pc_out   registered instruction and its address
//   instr_valid         instr_out is a real instruction (0 = bubble)
//   halted              high once a HALT word has been fetched
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INSTR_W   = 27,
  parameter int unsigned HAZ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall_in,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  pc_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0]         OP_JUMP   = 4'b1110;
  localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(27'h400_0000);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic                 halted_q, halted_d;

  logic [3:0]           opcode;
  logic [15:0]          imm_field;
  logic                 is_nop;
  logic                 is_jump;
  logic                 is_halt;
  logic                 issue;
  logic                 bubble;

  always_comb begin
    opcode    = rom_data[25:22];
    imm_field = rom_data[15:0];
    is_nop    = (rom_data == '0);
    is_halt   = (rom_data == HALT_WORD);
    is_jump   = (opcode == OP_JUMP);
  end

`ifdef HAZARD_INTERLOCK_EN
  localparam int unsigned CNT_W = $clog2(HAZ_DEPTH + 1);

  logic [CNT_W-1:0] busy_q [8];
  logic [CNT_W-1:0] busy_d [8];
  logic             imm_flag;
  logic [2:0]       rd_idx;
  logic [2:0]       rs_idx;
  logic             rs_busy;
  logic             rd_busy;
  logic             writes_rd;

  always_comb begin
    imm_flag  = rom_data[26];
    rd_idx    = rom_data[21:19];
    rs_idx    = rom_data[18:16];
    writes_rd = (opcode >= 4'd1) && (opcode <= 4'd11);
    // The issue cycle counts as the first busy cycle, so a counter at 1
    // expires on this edge and no longer blocks.
    rs_busy   = (busy_q[rs_idx] > CNT_W'(1));
    rd_busy   = (busy_q[rd_idx] > CNT_W'(1));
    bubble    = !is_nop && !is_jump && !is_halt &&
                (rs_busy || (!imm_flag && rd_busy));
  end

  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      busy_d[r] = busy_q[r];
      if ((state_q == S_RUN) && !stall_in && (busy_q[r] != '0)) begin
        busy_d[r] = busy_q[r] - CNT_W'(1);
      end
    end
    if (issue && writes_rd) begin
      busy_d[rd_idx] = CNT_W'(HAZ_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 8; r++) begin
        busy_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 8; r++) begin
        busy_q[r] <= busy_d[r];
      end
    end
  end
`else
  logic unused_haz_depth;

  always_comb begin
    bubble           = 1'b0;
    unused_haz_depth = ^HAZ_DEPTH;
  end
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    halted_d = halted_q;
    issue    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end

      S_RUN: begin
        if (br_taken) begin
          pc_d    = br_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (stall_in) begin
          // hold everything
        end else if (bubble) begin
          instr_d = '0;
          valid_d = 1'b0;
        end else if (is_halt) begin
          instr_d  = '0;
          valid_d  = 1'b0;
          pc_out_d = pc_q;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (is_jump) begin
          instr_d  = '0;
          valid_d  = 1'b0;
          pc_out_d = pc_q;
          pc_d     = ADDR_W'(imm_field);
        end else begin
          instr_d  = rom_data;
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
          issue    = 1'b1;
        end
      end

      S_HALT: begin
        // frozen until reset
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      halted_q <= halted_d;
    end
  end

  assign pc_addr     = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall_in;
  logic        br_taken;
  logic [15:0] br_target;
  logic [26:0] rom_data;
  logic [15:0] pc_addr;
  logic [26:0] instr_out;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic        halted;

  logic [26:0] rom [0:65535];

  int unsigned vectors;
  int unsigned miscompares;

  fetch_sequencer #(
    .ADDR_W   (16),
    .INSTR_W  (27),
    .HAZ_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall_in   (stall_in),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .rom_data   (rom_data),
    .pc_addr    (pc_addr),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .halted     (halted)
  );

  assign rom_data = rom[pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] enc(input logic imm_f, input logic [3:0] op,
                                      input logic [2:0] rd, input logic [2:0] rs,
                                      input logic [15:0] imm);
    return {imm_f, op, rd, rs, imm};
  endfunction

  function automatic logic [26:0] fill(input int unsigned a);
    return enc(1'b1, 4'd1, 3'd1, 3'd7, a[15:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc_addr"}, 32'(pc_addr), 32'h0);
    chk({tag, ".instr_out"}, 32'(instr_out), 32'h0);
    chk({tag, ".valid"}, 32'(instr_valid), 32'h0);
    chk({tag, ".pc_out"}, 32'(pc_out), 32'h0);
    chk({tag, ".halted"}, 32'(halted), 32'h0);
  endtask

  initial begin
    logic [26:0] w0;
    logic [26:0] w3;
    vectors     = 0;
    miscompares = 0;
    w0 = enc(1'b1, 4'd1, 3'd0, 3'd0, 16'd5);
    w3 = enc(1'b1, 4'd2, 3'd2, 3'd7, 16'd9);
    for (int i = 0; i < 65536; i++) rom[i] = fill(i);
    rom[0]   = w0;
    rom[1]   = '0;
    rom[2]   = '0;
    rom[3]   = w3;
    rom[158] = enc(1'b0, 4'b1110, 3'd0, 3'd0, 16'd83);
    rom[172] = 27'h400_0000;

    rst_n = 1'b0; start = 1'b0; stall_in = 1'b0; br_taken = 1'b0; br_target = '0;

    // 1: reset, start, sequential fetch
    step(); step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk("idle.valid", 32'(instr_valid), 32'h0);
    chk("idle.pc_addr", 32'(pc_addr), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start.pc_addr", 32'(pc_addr), 32'h0);
    chk("start.valid", 32'(instr_valid), 32'h0);
    step();
    chk("f0.instr", 32'(instr_out), 32'(w0));
    chk("f0.pc_out", 32'(pc_out), 32'd0);
    chk("f0.valid", 32'(instr_valid), 32'h1);
    chk("f0.pc_addr", 32'(pc_addr), 32'd1);
    step();
    chk("f1.instr", 32'(instr_out), 32'h0);
    chk("f1.pc_out", 32'(pc_out), 32'd1);
    chk("f1.valid", 32'(instr_valid), 32'h1);
    step();
    chk("f2.pc_out", 32'(pc_out), 32'd2);
    chk("f2.pc_addr", 32'(pc_addr), 32'd3);
    step();
    chk("f3.instr", 32'(instr_out), 32'(w3));
    chk("f3.pc_out", 32'(pc_out), 32'd3);

    // 2: stall at PC=5
    step();
    chk("f4.pc_out", 32'(pc_out), 32'd4);
    chk("f4.pc_addr", 32'(pc_addr), 32'd5);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall.pc_out", 32'(pc_out), 32'd4);
      chk("stall.instr", 32'(instr_out), 32'(fill(4)));
      chk("stall.pc_addr", 32'(pc_addr), 32'd5);
      chk("stall.valid", 32'(instr_valid), 32'h1);
    end
    stall_in = 1'b0;
    step();
    chk("resume.pc_out", 32'(pc_out), 32'd5);
    chk("resume.instr", 32'(instr_out), 32'(fill(5)));
    chk("resume.pc_addr", 32'(pc_addr), 32'd6);

    // 3: JUMP at 158 -> 83, then branch together with stall
    br_taken = 1'b1; br_target = 16'd158;
    step();
    br_taken = 1'b0;
    chk("br158.pc_addr", 32'(pc_addr), 32'd158);
    chk("br158.valid", 32'(instr_valid), 32'h0);
    chk("br158.instr", 32'(instr_out), 32'h0);
    step();
    chk("jump.valid", 32'(instr_valid), 32'h0);
    chk("jump.pc_addr", 32'(pc_addr), 32'd83);
    step();
    chk("f83.valid", 32'(instr_valid), 32'h1);
    chk("f83.pc_out", 32'(pc_out), 32'd83);
    chk("f83.instr", 32'(instr_out), 32'(fill(83)));
    br_taken = 1'b1; br_target = 16'd145; stall_in = 1'b1;
    step();
    br_taken = 1'b0; stall_in = 1'b0;
    chk("br145.valid", 32'(instr_valid), 32'h0);
    chk("br145.pc_addr", 32'(pc_addr), 32'd145);
    step();
    chk("f145.valid", 32'(instr_valid), 32'h1);
    chk("f145.pc_out", 32'(pc_out), 32'd145);

    // 4: HALT at 172
    br_taken = 1'b1; br_target = 16'd170;
    step();
    br_taken = 1'b0;
    step();
    chk("f170.pc_out", 32'(pc_out), 32'd170);
    step();
    chk("f171.pc_out", 32'(pc_out), 32'd171);
    chk("f171.halted", 32'(halted), 32'h0);
    step();
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.valid", 32'(instr_valid), 32'h0);
    chk("halt.pc_addr", 32'(pc_addr), 32'd172);
    br_taken = 1'b1; br_target = 16'd5; start = 1'b1;
    step();
    step();
    br_taken = 1'b0; start = 1'b0;
    chk("halt_hold.halted", 32'(halted), 32'h1);
    chk("halt_hold.pc_addr", 32'(pc_addr), 32'd172);
    chk("halt_hold.valid", 32'(instr_valid), 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero("rst_after_halt");
    step();
    chk("idle2.pc_addr", 32'(pc_addr), 32'h0);
    chk("idle2.valid", 32'(instr_valid), 32'h0);

    // 5: PC wrap
    start = 1'b1;
    step();
    start = 1'b0;
    br_taken = 1'b1; br_target = 16'hFFFF;
    step();
    br_taken = 1'b0;
    chk("wrap.pc_addr0", 32'(pc_addr), 32'hFFFF);
    step();
    chk("wrap.pc_out", 32'(pc_out), 32'hFFFF);
    chk("wrap.pc_addr", 32'(pc_addr), 32'h0);
    chk("wrap.valid", 32'(instr_valid), 32'h1);
    step();
    chk("wrap.f0", 32'(pc_out), 32'h0);

    // 6: RAW dependency on r0
    rst_n = 1'b0;
    rom[1] = enc(1'b0, 4'd1, 3'd3, 3'd0, 16'd0);
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("haz.f0.pc_out", 32'(pc_out), 32'd0);
    chk("haz.f0.valid", 32'(instr_valid), 32'h1);
`ifdef HAZARD_INTERLOCK_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("haz.bubble.valid", 32'(instr_valid), 32'h0);
      chk("haz.bubble.pc_addr", 32'(pc_addr), 32'd1);
    end
`endif
    step();
    chk("haz.f1.valid", 32'(instr_valid), 32'h1);
    chk("haz.f1.pc_out", 32'(pc_out), 32'd1);
    chk("haz.f1.instr", 32'(instr_out), 32'(enc(1'b0, 4'd1, 3'd3, 3'd0, 16'd0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
